// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative HiLo multiply/divide engine.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_WRITE
   } state_e;

   localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

   function automatic logic op_is_div(input op_e op);
      return op[1];
   endfunction

   function automatic logic op_signed(input op_e op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the engine: shift-add multiply or restoring divide.
// Multiply: acc = {partial high, multiplier}; divide: acc = {remainder, quotient}.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  op_e                  op,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   acc_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_s;
   logic [WIDTH-1:0] diff;

   // Next accumulator for either operation class.
   always_comb begin
      sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      rem_s = acc[2*WIDTH-1:WIDTH-1];
      // When the trial subtract succeeds the true difference is below the
      // divisor, so the low WIDTH bits hold it exactly.
      diff  = rem_s[WIDTH-1:0] - operand;
      if (op_is_div(op)) begin
         if (rem_s >= {1'b0, operand}) begin
            acc_next = {diff, acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {rem_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_next = {sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the HiLo write port.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Start,
   input  logic [1:0]           Op,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 Stall,
   output logic                 Busy,
   output logic                 HiLoEn,
   output logic [2*WIDTH-1:0]   HiLoWrite,
   output logic                 Done,
   output logic                 DivByZero
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_e               state, state_next;
   op_e                  op_in, op_q;
   logic                 sign_a, sign_b, div0_q;
   logic                 a_neg, b_neg, start_div0;
   logic [WIDTH-1:0]     a_mag, b_mag, opnd_q;
   logic [2*WIDTH-1:0]   acc, step_acc, fixed, hilo_q;
   logic [CW-1:0]        cnt;

   assign op_in      = op_e'(Op);
   assign a_neg      = op_signed(op_in) & A[WIDTH-1];
   assign b_neg      = op_signed(op_in) & B[WIDTH-1];
   assign a_mag      = a_neg ? -A : A;
   assign b_mag      = b_neg ? -B : B;
   assign start_div0 = op_is_div(op_in) && (B == '0);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op       (op_q),
      .acc      (acc),
      .operand  (opnd_q),
      .acc_next (step_acc)
   );

   // Sign fixup of the magnitude result; divide-by-zero result is preloaded.
   always_comb begin
      fixed = acc;
      if (div0_q) begin
         fixed = acc;
      end else if (op_is_div(op_q)) begin
         fixed[WIDTH-1:0]       = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         fixed[2*WIDTH-1:WIDTH] = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end else if (sign_a ^ sign_b) begin
         fixed = -acc;
      end
   end

   // Next state and per-state outputs.
   always_comb begin
      state_next = state;
      Stall      = 1'b0;
      Busy       = 1'b0;
      HiLoEn     = 1'b0;
      Done       = 1'b0;
      DivByZero  = 1'b0;
      HiLoWrite  = hilo_q;
      unique case (state)
         S_IDLE: begin
            if (Start) begin
               Stall      = 1'b1;
               state_next = start_div0 ? S_WRITE : S_RUN;
            end
         end
         S_RUN: begin
            Stall = 1'b1;
            Busy  = 1'b1;
            if (cnt == CW'(WIDTH - 1)) state_next = S_WRITE;
         end
         S_WRITE: begin
            Busy       = 1'b1;
            HiLoEn     = 1'b1;
            Done       = 1'b1;
            DivByZero  = div0_q;
            HiLoWrite  = fixed;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Operand latch, iteration datapath and HiLo hold register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         op_q   <= OP_MULT;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         div0_q <= 1'b0;
         opnd_q <= '0;
         acc    <= '0;
         cnt    <= '0;
         hilo_q <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (Start) begin
                  op_q   <= op_in;
                  sign_a <= a_neg;
                  sign_b <= b_neg;
                  div0_q <= start_div0;
                  cnt    <= '0;
                  if (start_div0) begin
                     acc    <= {A, WIDTH'(DIV0_LO)};
                     opnd_q <= B;
                  end else if (op_is_div(op_in)) begin
                     acc    <= {{WIDTH{1'b0}}, a_mag};
                     opnd_q <= b_mag;
                  end else begin
                     acc    <= {{WIDTH{1'b0}}, b_mag};
                     opnd_q <= a_mag;
                  end
               end
            end
            S_RUN: begin
               acc <= step_acc;
               if (cnt != CW'(WIDTH - 1)) cnt <= cnt + 1'b1;
            end
            S_WRITE: hilo_q <= fixed;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle multiply/divide engine and sequencer for the HiLo register path of the single-cycle MIPS datapath.
- Accepts MULT/MULTU/DIV/DIVU requests decoded from the current instruction and holds the PC (Stall) while it iterates.
- Writes the 64-bit {Hi,Lo} result through the HiLo write port when it finishes.
- Replaces the combinational multiply/divide in the ALU, so the single-cycle critical path no longer includes a 32x32 multiplier or divider.

Parameters:
- WIDTH, 32, operand width; HiLo result is 2*WIDTH. Only 32 is verified.

Ports:
- Clk  in  1  datapath clock (divided clock domain)
- Rst  in  1  synchronous, active-high reset
- Start  in  1  request from the controller; level, held while the MULT/DIV instruction is in IM
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  in  WIDTH  rs operand (RF read data 1)
- B  in  WIDTH  rt operand (RF read data 2)
- Stall  out  1  hold PC and block RF/DM writes this cycle
- Busy  out  1  engine not in IDLE
- HiLoEn  out  1  HiLo write enable, one cycle
- HiLoWrite  out  2*WIDTH  {Hi,Lo} result
- Done  out  1  one-cycle pulse, coincident with HiLoEn
- DivByZero  out  1  one-cycle pulse with Done when DIV/DIVU had B==0

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, operand registers 0. Reset mid-operation aborts the operation with no HiLoEn pulse. Reset takes priority over every other event.
- States:
  - IDLE -> RUN on Start, unless DIV/DIVU with B==0.
  - IDLE -> WRITE on Start with DIV/DIVU and B==0.
  - RUN -> WRITE when the step counter reaches WIDTH-1.
  - WRITE -> IDLE unconditionally.
- Cycle 0 is the IDLE cycle with Start=1:
  - Latch Op, the sign flags, |A| and |B|. Magnitudes are used only for signed ops; unsigned ops take operands as-is.
  - Clear the accumulator and the counter.
  - Stall is combinational in this cycle: Stall = Start & IDLE.
- Cycles 1..WIDTH are RUN, one bit per cycle. Stall=1, Busy=1.
  - Multiply: shift-add. If the multiplier LSB is set, add the multiplicand to the upper half, then shift the 64-bit product right by 1.
  - Divide: restoring. Shift the remainder:quotient pair left by 1, trial-subtract the divisor, keep the result if it is non-negative and set the quotient bit.
- Cycle WIDTH+1 is WRITE. Stall=0, Busy=1, HiLoEn=1, Done=1.
  - HiLoWrite is valid; HiLo and PC both update at the end of this cycle.
  - Total latency for a normal operation: WIDTH+2 cycles (34).
- Sign fixup, applied combinationally in WRITE:
  - MULT: negate the 64-bit product if signA xor signB.
  - DIV: quotient negated if signA xor signB; remainder takes the sign of A (truncating division).
  - Result placement: Lo = quotient, Hi = remainder. For multiply, {Hi,Lo} = product.
- Divide by zero:
  - Hi = A as latched, Lo = all ones, DivByZero=1 in WRITE.
  - Latency 2 cycles; Stall is high in cycle 0 only.
- Start in RUN or WRITE is ignored. The instruction is still fetched during WRITE, so this is required to prevent a restart.
- Start is not re-sampled until IDLE. Back-to-back MULT/DIV instructions therefore start on the cycle after WRITE.
- Changes on A, B or Op after cycle 0 have no effect.
- Counter width is clog2(WIDTH). The counter saturates only via the state transition and never wraps in RUN.
- HiLoWrite holds its last value outside WRITE. Consumers qualify it with HiLoEn.

Decomposition:
- Shared package `muldiv_pkg` holds:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encodings: S_IDLE, S_RUN, S_WRITE.
  - DIV0_LO = 32'hFFFFFFFF.
- One sub-module `muldiv_step`, purely combinational: one shift-add or restoring-subtract iteration.
  - Inputs: Op class, accumulator, operand.
  - Outputs: next accumulator.
- The sequencer owns the FSM, counter, sign latch, fixup and outputs.

Test Plan:
- MULT A=7, B=0xFFFFFFFD (-3) -> HiLoEn only in cycle 33, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, Stall high in cycles 0..32, low in 33.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, Done pulse width 1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); DIVU A=100, B=7 -> Lo=14, Hi=2.
- DIVU A=0x12345678, B=0 -> DivByZero=1 and HiLoEn=1 in cycle 1, Hi=0x12345678, Lo=0xFFFFFFFF, Stall high in cycle 0 only.
- Start held high continuously with A/B changed mid-RUN -> exactly one HiLoEn per request at 34-cycle spacing plus 1, result uses cycle-0 operands.
- Rst asserted in RUN cycle 10 -> next cycle all outputs 0, Busy=0, no HiLoEn ever issued for the aborted op; new Start after reset completes normally.
